product_accumulator: RTL and testbench

- Downstream stage of the 8x8 shift-and-add multiplier.
- Consumes its registered 16-bit products through a valid/ready handshake.
- Sums a programmable-length frame of products into a wider saturating accumulator.
- Presents the frame total on a held output with valid/ready. Used for dot-product and filter-tap summation after the multiplier.

---
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmable-length frame of unsigned products into a
// saturating accumulator and presents the total through a valid/ready result port.
`default_nettype none

module product_accumulator #(
  parameter int P_W   = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] frame_len_i,
  input  logic             prod_valid_i,
  input  logic [P_W-1:0]   prod_i,
  output logic             prod_ready_o,
  output logic [ACC_W-1:0] acc_out_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [ACC_W:0]   sum_w;
  logic [CNT_W-1:0] cnt_inc_w;

  // One extra bit on the sum exposes the carry used for saturation.
  assign sum_w     = {1'b0, acc_q} + {{(ACC_W + 1 - P_W){1'b0}}, prod_i};
  assign cnt_inc_w = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          len_d = frame_len_i;
          state_d = (frame_len_i == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (prod_valid_i) begin
          if (sum_w[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_w[ACC_W-1:0];
          end
          cnt_d = cnt_inc_w;
          if (cnt_inc_w == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (acc_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Handshake flags decode straight from state so no input reaches an output.
  assign prod_ready_o = (state_q == S_ACCUM);
  assign acc_valid_o  = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign acc_out_o    = acc_q;
  assign overflow_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 24-bit and a 17-bit instance share stimulus and are
// checked against an unbounded-sum frame model plus hand-computed frame totals.
`default_nettype none

module tb_product_accumulator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  frame_len_i = '0;
  logic        prod_valid_i = 1'b0;
  logic [15:0] prod_i = '0;
  logic        acc_ready_i = 1'b0;

  logic        pr24, av24, ov24, bz24;
  logic [23:0] ao24;
  logic        pr17, av17, ov17, bz17;
  logic [16:0] ao17;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  product_accumulator dut24 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .frame_len_i(frame_len_i),
    .prod_valid_i(prod_valid_i), .prod_i(prod_i), .prod_ready_o(pr24),
    .acc_out_o(ao24), .acc_valid_o(av24), .acc_ready_i(acc_ready_i),
    .overflow_o(ov24), .busy_o(bz24)
  );

  product_accumulator #(.ACC_W(17)) dut17 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .frame_len_i(frame_len_i),
    .prod_valid_i(prod_valid_i), .prod_i(prod_i), .prod_ready_o(pr17),
    .acc_out_o(ao17), .acc_valid_o(av17), .acc_ready_i(acc_ready_i),
    .overflow_o(ov17), .busy_o(bz17)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: 0 = idle, 1 = collecting, 2 = result held. The true sum is kept
  // unbounded and clipped per accumulator width when compared.
  int     m_phase = 0;
  int     m_rem = 0;
  longint m_sum = 0;

  function automatic longint sat(input longint s, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  function automatic longint ovf(input longint s, input int w);
    return (s > ((longint'(1) << w) - 1)) ? 1 : 0;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_sum   <= 0;
    end else begin
      case (m_phase)
        0: if (start_i) begin
          m_sum   <= 0;
          m_rem   <= int'(frame_len_i);
          m_phase <= (frame_len_i == 8'd0) ? 2 : 1;
        end
        1: if (prod_valid_i) begin
          m_sum <= m_sum + longint'(prod_i);
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_phase <= 2;
        end
        default: if (acc_ready_i) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk_i) begin
    check("prod_ready24", longint'(pr24), longint'(m_phase == 1));
    check("acc_valid24", longint'(av24), longint'(m_phase == 2));
    check("busy24", longint'(bz24), longint'(m_phase != 0));
    check("prod_ready17", longint'(pr17), longint'(m_phase == 1));
    check("acc_valid17", longint'(av17), longint'(m_phase == 2));
    if (m_phase == 2) begin
      check("acc_out24", longint'(ao24), sat(m_sum, 24));
      check("overflow24", longint'(ov24), ovf(m_sum, 24));
      check("acc_out17", longint'(ao17), sat(m_sum, 17));
      check("overflow17", longint'(ov17), ovf(m_sum, 17));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_frame(input logic [7:0] len);
    start_i = 1'b1;
    frame_len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] p, input int gap);
    prod_valid_i = 1'b0;
    repeat (gap) tick();
    prod_valid_i = 1'b1;
    prod_i = p;
    tick();
    prod_valid_i = 1'b0;
  endtask

  // Waits (bounded) for the result, checks literals for both widths, then accepts it.
  task automatic expect_result(input string name, input longint e24, input longint o24,
                               input longint e17, input longint o17, input bit accept);
    int n = 0;
    while (!av24 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, longint'(n), 0);
    check({name, "_lit24"}, longint'(ao24), e24);
    check({name, "_litovf24"}, longint'(ov24), o24);
    check({name, "_lit17"}, longint'(ao17), e17);
    check({name, "_litovf17"}, longint'(ov17), o17);
    check({name, "_model24"}, sat(m_sum, 24), e24);
    if (accept) begin
      acc_ready_i = 1'b1;
      tick();
      acc_ready_i = 1'b0;
    end
  endtask

  initial begin
    repeat (2) tick();
    check("rst_acc_out", longint'(ao24), 0);
    check("rst_flags", longint'({av24, pr24, ov24, bz24}), 0);
    rst_ni = 1'b1;
    tick();

    start_frame(8'd3);
    send(16'h00FF, 0);
    send(16'h0100, 0);
    send(16'h0001, 0);
    expect_result("t1", 64'h000200, 0, 64'h00200, 0, 1'b1);

    start_frame(8'd3);
    repeat (3) send(16'hFFFF, 0);
    expect_result("t2", 64'h02FFFD, 0, 64'h1FFFF, 1, 1'b1);
    start_frame(8'd1);
    send(16'h0001, 0);
    expect_result("t2b", 64'h000001, 0, 64'h00001, 0, 1'b1);

    start_frame(8'd0);
    check("len0_ready", longint'(pr24), 0);
    expect_result("t3", 0, 0, 0, 0, 1'b1);

    start_frame(8'd2);
    send(16'h1234, 0);
    send(16'h0010, 3);
    expect_result("t4", 64'h001244, 0, 64'h01244, 0, 1'b0);
    frame_len_i = 8'd5;
    for (int i = 0; i < 5; i++) begin
      start_i = i[0];
      tick();
      check("hold_acc", longint'(ao24), 64'h001244);
      check("hold_ready", longint'({pr24, av24}), 1);
    end
    start_i = 1'b1;
    acc_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    acc_ready_i = 1'b0;
    tick();
    check("start_ignored_in_done", longint'(bz24), 0);

    start_frame(8'd255);
    for (int i = 0; i < 255; i++) send(16'hFFFF, 0);
    expect_result("t5", 64'hFEFF01, 0, 64'h1FFFF, 1, 1'b1);

    start_frame(8'd4);
    send(16'h0007, 0);
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst_acc", longint'(ao24), 0);
    check("async_rst_flags", longint'({av24, pr24, ov24, bz24}), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_idle", longint'(bz24), 0);
    start_frame(8'd1);
    send(16'h0005, 0);
    expect_result("t6", 64'h000005, 0, 64'h00005, 0, 1'b1);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
